half_adder_checker: RTL

// - On-board response checker for the half_adder lab: the receiving end of the half_adder stimulus flow.
// - Drives exhaustive {a,b} vectors 00,01,10,11 into a half_adder DUT; b toggles fastest.
// - Samples the DUT's S/C after a settle window and compares them against a^b and a&b.
// - Reports pass/fail, the error count and the first failing vector. Sits beside the DUT on the FPGA, all in one clock domain.

---
 rtl/half_adder_checker_pkg.sv | 23 ++
 rtl/half_adder_checker_settle.sv | 28 ++
 rtl/half_adder_checker.sv | 129 ++++++++++++
 3 files changed

// File: rtl/half_adder_checker_pkg.sv
// Shared types and helpers for the half_adder response checker.
// Holds FSM state encoding, vector width and the reference function.
package half_adder_checker_pkg;

  localparam int VEC_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  // Returns {carry, sum} for an ideal half adder.
  function automatic logic [1:0] expected_sc(
    input logic a,
    input logic b
  );
    return {a & b, a ^ b};
  endfunction

endpackage

// File: rtl/half_adder_checker_settle.sv
// settle_timer: loadable down-counter for the settle window.
// Ports: clk, rst_n, load, en, value (load value), zero (count==0).
module settle_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (en) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/half_adder_checker.sv
// Drives exhaustive {a,b} vectors into a half_adder and checks S/C.
// Ports: clk, rst_n, start, a_out/b_out (to DUT), s_in/c_in (from
// DUT), busy, done, pass, err_count, fail_vec (results).
module half_adder_checker
  import half_adder_checker_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int NUM_PASSES    = 1,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a_out,
  output logic             b_out,
  input  logic             s_in,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       fail_vec
);

  localparam int TW = $clog2(SETTLE_CYCLES) + 1;
  localparam int PW = $clog2(NUM_PASSES) + 1;

  localparam logic [TW-1:0] T_LOAD = TW'(SETTLE_CYCLES - 1);
  localparam logic [PW-1:0] P_LAST = PW'(NUM_PASSES - 1);

  state_t           state;
  logic [VEC_W-1:0] vec;
  logic [PW-1:0]    pass_cnt;

  logic             t_load;
  logic             t_en;
  logic             t_zero;

  logic             mismatch;
  logic [ERR_W-1:0] err_next;
  logic             last_vec;

  settle_timer #(
    .W (TW)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (t_load),
    .en    (t_en),
    .value (T_LOAD),
    .zero  (t_zero)
  );

  assign t_load = (state == ST_DRIVE);
  assign t_en   = (state == ST_SETTLE) && !t_zero;

  // One error per vector, however many bits differ.
  always_comb begin
    mismatch = ({c_in, s_in} != expected_sc(a_out, b_out));
    err_next = err_count;
    if (mismatch && (err_count != '1)) begin
      err_next = err_count + 1'b1;
    end
  end

  assign last_vec = (vec == 2'd3) && (pass_cnt == P_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      vec       <= '0;
      pass_cnt  <= '0;
      a_out     <= 1'b0;
      b_out     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_vec  <= '0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state     <= ST_DRIVE;
            vec       <= '0;
            pass_cnt  <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_vec  <= '0;
          end
        end
        ST_DRIVE: begin
          a_out <= vec[1];
          b_out <= vec[0];
          state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (t_zero) begin
            state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          err_count <= err_next;
          if (mismatch && (err_count == '0)) begin
            fail_vec <= {a_out, b_out};
          end
          if (last_vec) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            state <= ST_DRIVE;
            if (vec == 2'd3) begin
              vec      <= '0;
              pass_cnt <= pass_cnt + 1'b1;
            end else begin
              vec <= vec + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
